// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// The group carry chain is spread over STAGES valid/ready stages.
module cla_pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int NG = WIDTH / GROUP;
   localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;
   localparam int L  = STAGES - 1;

   logic [STAGES-1:0] v_q;
   logic [STAGES-1:0] vin;
   logic [STAGES-1:0] rdy;

   logic [WIDTH-1:0]  p_q [NR];
   logic [WIDTH-1:0]  g_q [NR];
   logic [NG:0]       c_q [NR];

   logic [WIDTH-1:0]  pw [STAGES];
   logic [WIDTH-1:0]  gw [STAGES];
   logic [NG:0]       cw [STAGES];
   logic [NG:0]       cn [STAGES];

   logic [WIDTH-1:0]  bp;
   logic [WIDTH-1:0]  sum_d;
   logic              cout_d;
   logic              ovf_d;
   logic              cmsb;

   logic [WIDTH-1:0]  sum_q;
   logic              cout_q;
   logic              ovf_q;
   logic              zero_q;

   function automatic int grp_lo(input int k);
      return (k * NG) / STAGES;
   endfunction

   function automatic int grp_hi(input int k);
      return ((k + 1) * NG) / STAGES;
   endfunction

   // stage ready chain: a stage may load when empty or when it drains
   always_comb begin
      rdy = '0;
      vin = '0;
      rdy[L] = ~v_q[L] | out_ready;
      for (int k = STAGES - 2; k >= 0; k--)
         rdy[k] = ~v_q[k] | rdy[k+1];
      vin[0] = in_valid;
      for (int k = 1; k < STAGES; k++)
         vin[k] = v_q[k-1];
   end

   // carry chain: stage k resolves its slice of group carries
   always_comb begin
      logic gp;
      logic gg;
      logic cb;
      int   i;
      gp     = 1'b0;
      gg     = 1'b0;
      cb     = 1'b0;
      i      = 0;
      sum_d  = '0;
      cmsb   = 1'b0;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
      bp     = sub ? ~b : b;
      for (int k = 0; k < STAGES; k++) begin
         pw[k] = '0;
         gw[k] = '0;
         cw[k] = '0;
         cn[k] = '0;
      end
      pw[0]    = a ^ bp;
      gw[0]    = a & bp;
      cw[0][0] = sub | carry_in;
      for (int k = 1; k < STAGES; k++) begin
         pw[k] = p_q[k-1];
         gw[k] = g_q[k-1];
         cw[k] = c_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         cn[k] = cw[k];
         for (int g = 0; g < NG; g++) begin
            if (g >= grp_lo(k) && g < grp_hi(k)) begin
               gp = 1'b1;
               gg = 1'b0;
               for (int j = 0; j < GROUP; j++) begin
                  i  = g * GROUP + j;
                  gg = gw[k][i] | (pw[k][i] & gg);
                  gp = gp & pw[k][i];
               end
               cn[k][g+1] = gg | (gp & cn[k][g]);
            end
         end
      end
      for (int g = 0; g < NG; g++) begin
         cb = cn[L][g];
         for (int j = 0; j < GROUP; j++) begin
            i        = g * GROUP + j;
            sum_d[i] = pw[L][i] ^ cb;
            cmsb     = cb;
            cb       = gw[L][i] | (pw[L][i] & cb);
         end
      end
      cout_d = cn[L][NG];
      ovf_d  = cmsb ^ cout_d;
   end

   // stage registers; reset drops every in-flight beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         for (int r = 0; r < NR; r++) begin
            p_q[r] <= '0;
            g_q[r] <= '0;
            c_q[r] <= '0;
         end
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++)
            if (rdy[k])
               v_q[k] <= vin[k];
         for (int k = 0; k < STAGES - 1; k++) begin
            if (rdy[k] && vin[k]) begin
               p_q[k] <= pw[k];
               g_q[k] <= gw[k];
               c_q[k] <= cn[k];
            end
         end
         if (rdy[L] && vin[L]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= (sum_d == '0);
         end
      end
   end

   assign in_ready  = rdy[0];
   assign out_valid = v_q[L];
   assign sum       = sum_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and randomized checks of cla_pipe_adder
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_cla_pipe_adder;

   localparam int NX = 6;
   localparam int XG [NX] = '{4, 2, 4, 8, 8, 2};
   localparam int XS [NX] = '{2, 1, 3, 4, 2, 4};
   localparam int T  = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        out_ready;
   logic        carry_in;
   logic        sub;
   logic [31:0] a;
   logic [31:0] b;

   logic        x_ird [NX];
   logic        x_ov  [NX];
   logic        x_co  [NX];
   logic        x_of  [NX];
   logic        x_z   [NX];
   logic [31:0] x_s   [NX];

   int vec = 0;
   int bad = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NX; k++) begin : g_dut
      cla_pipe_adder #(
         .WIDTH (32),
         .GROUP (XG[k]),
         .STAGES(XS[k])
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .in_valid (in_valid),
         .in_ready (x_ird[k]),
         .a        (a),
         .b        (b),
         .carry_in (carry_in),
         .sub      (sub),
         .out_valid(x_ov[k]),
         .out_ready(out_ready),
         .sum      (x_s[k]),
         .carry_out(x_co[k]),
         .overflow (x_of[k]),
         .zero     (x_z[k])
      );
   end

   // {overflow, zero, carry_out, sum} from plain integer arithmetic
   function automatic logic [34:0] model(input logic [31:0] ma,
                                         input logic [31:0] mb,
                                         input logic mci,
                                         input logic msub);
      longint      sa, sb, sr;
      logic [32:0] ur;
      logic [31:0] s;
      logic        co, ov;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (msub) begin
         ur = {1'b0, ma} - {1'b0, mb};
         co = (ma >= mb);
         sr = sa - sb;
      end else begin
         ur = {1'b0, ma} + {1'b0, mb} + {32'b0, mci};
         co = ur[32];
         sr = sa + sb + (mci ? 64'sd1 : 64'sd0);
      end
      s  = ur[31:0];
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {ov, (s == 32'b0), co, s};
   endfunction

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      carry_in  = 1'b0;
      sub       = 1'b0;
      #12;
      vec++;
      if ({x_ov[0], x_s[0], x_co[0], x_of[0], x_z[0]} !== 36'b0) begin
         bad++;
         $display("FAIL rst_outs: got %h exp 0",
                  {x_ov[0], x_s[0], x_co[0], x_of[0], x_z[0]});
      end
      vec++;
      if (x_ird[0] !== 1'b1) begin
         bad++;
         $display("FAIL rst_ready: got %b exp 1", x_ird[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] ta [4];
      logic [31:0] tb [4];
      logic [3:0]  tci;
      logic [3:0]  tsub;
      logic [34:0] te [4];
      logic [34:0] got;
      int          lat;
      ta   = '{32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFFF, 32'h80000000};
      tb   = '{32'h00000001, 32'h00000007, 32'h00000001, 32'h00000001};
      tci  = 4'b0010;
      tsub = 4'b1010;
      te   = '{{3'b011, 32'h00000000}, {3'b000, 32'hFFFFFFFE},
               {3'b100, 32'h80000000}, {3'b101, 32'h7FFFFFFF}};
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         a         = ta[n];
         b         = tb[n];
         carry_in  = tci[n];
         sub       = tsub[n];
         in_valid  = 1'b1;
         out_ready = 1'b1;
         #1;
         vec++;
         if (x_ird[0] !== 1'b1) begin
            bad++;
            $display("FAIL dir_ready[%0d]: got %b exp 1", n, x_ird[0]);
         end
         @(negedge clk);
         in_valid = 1'b0;
         lat = 1;
         while (x_ov[0] !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
         end
         vec++;
         if (lat !== 2) begin
            bad++;
            $display("FAIL dir_latency[%0d]: got %0d exp 2", n, lat);
         end
         got = {x_of[0], x_z[0], x_co[0], x_s[0]};
         vec++;
         if (got !== te[n]) begin
            bad++;
            $display("FAIL dir_result[%0d]: got %h exp %h", n, got, te[n]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [34:0] q [$];
      logic [34:0] held;
      logic [34:0] got;
      logic [34:0] e;
      logic        hold;
      int          sent, rcv;
      sent = 0;
      rcv  = 0;
      hold = 1'b0;
      held = '0;
      for (int c = 0; c < 60 && rcv < 10; c++) begin
         @(negedge clk);
         out_ready = !(c >= 3 && c <= 5);
         in_valid  = (sent < 10);
         a         = $urandom;
         b         = $urandom;
         carry_in  = 1'($urandom);
         sub       = 1'($urandom);
         #1;
         got = {x_of[0], x_z[0], x_co[0], x_s[0]};
         if (hold) begin
            vec++;
            if (x_ov[0] !== 1'b1 || got !== held) begin
               bad++;
               $display("FAIL bp_hold c%0d: got %b/%h exp 1/%h",
                        c, x_ov[0], got, held);
            end
         end
         vec++;
         if (x_ird[0] !== (q.size() < 2 || out_ready)) begin
            bad++;
            $display("FAIL bp_ready c%0d: got %b exp %b", c, x_ird[0],
                     (q.size() < 2 || out_ready));
         end
         if (x_ov[0] === 1'b1 && out_ready) begin
            vec++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL bp_extra c%0d: got %h exp none", c, got);
            end else begin
               e = q.pop_front();
               if (got !== e) begin
                  bad++;
                  $display("FAIL bp_data c%0d: got %h exp %h", c, got, e);
               end
            end
            rcv++;
         end
         if (in_valid && x_ird[0] === 1'b1) begin
            q.push_back(model(a, b, carry_in, sub));
            sent++;
         end
         hold = (x_ov[0] === 1'b1) && !out_ready;
         held = got;
      end
      vec++;
      if (rcv !== 10) begin
         bad++;
         $display("FAIL bp_count: got %0d exp 10", rcv);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [34:0] e;
      logic [34:0] got;
      int          lat;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = $urandom;
      b         = $urandom;
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      vec++;
      if (x_ov[0] !== 1'b1) begin
         bad++;
         $display("FAIL mid_inflight: got %b exp 1", x_ov[0]);
      end
      #1 rst_n = 1'b0;
      #1;
      vec++;
      if (x_ov[0] !== 1'b0 || x_ird[0] !== 1'b1) begin
         bad++;
         $display("FAIL mid_flush: got v%b r%b exp v0 r1", x_ov[0], x_ird[0]);
      end
      vec++;
      if ({x_s[0], x_co[0], x_of[0], x_z[0]} !== 35'b0) begin
         bad++;
         $display("FAIL mid_outs: got %h exp 0",
                  {x_s[0], x_co[0], x_of[0], x_z[0]});
      end
      @(negedge clk);
      a         = $urandom;
      b         = $urandom;
      carry_in  = 1'b1;
      sub       = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      e = model(a, b, carry_in, sub);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (x_ov[0] !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      vec++;
      if (lat !== 2) begin
         bad++;
         $display("FAIL mid_latency: got %0d exp 2", lat);
      end
      got = {x_of[0], x_z[0], x_co[0], x_s[0]};
      vec++;
      if (got !== e) begin
         bad++;
         $display("FAIL mid_result: got %h exp %h", got, e);
      end
   endtask

   task automatic test_sweep();
      logic [34:0] ex [T];
      logic [34:0] got;
      logic        ev;
      int          d;
      @(negedge clk);
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < T + 5; t++) begin
         for (int k = 0; k < NX; k++) begin
            d   = t - XS[k];
            ev  = (d >= 0 && d < T);
            got = {x_of[k], x_z[k], x_co[k], x_s[k]};
            vec++;
            if (x_ov[k] !== ev) begin
               bad++;
               $display("FAIL sweep_valid dut%0d t%0d: got %b exp %b",
                        k, t, x_ov[k], ev);
            end else if (ev && got !== ex[d]) begin
               bad++;
               $display("FAIL sweep_data dut%0d t%0d: got %h exp %h",
                        k, t, got, ex[d]);
            end
         end
         in_valid = (t < T);
         a        = (t % 8 == 0) ? 32'hFFFFFFFF : $urandom;
         b        = (t % 11 == 0) ? 32'h00000001 : $urandom;
         carry_in = 1'($urandom);
         sub      = 1'($urandom);
         if (t < T)
            ex[t] = model(a, b, carry_in, sub);
         #1;
         if (t < T) begin
            for (int k = 0; k < NX; k++) begin
               vec++;
               if (x_ird[k] !== 1'b1) begin
                  bad++;
                  $display("FAIL sweep_ready dut%0d t%0d: got %b exp 1",
                           k, t, x_ird[k]);
               end
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no end exp finish");
      $fatal(1);
   end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal values 4..64.
REQ-002 Parameter GROUP, default 4: carry-lookahead group size in bits; GROUP SHALL divide WIDTH.
REQ-003 Parameter STAGES, default 2: pipeline register stages, legal values 1..4, and never more than WIDTH/GROUP.
REQ-004 Port clk, input, 1 bit: single clock; all registers update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: the operand beat is valid.
REQ-007 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 Port a, input, WIDTH bits: operand A.
REQ-009 Port b, input, WIDTH bits: operand B.
REQ-010 Port carry_in, input, 1 bit: carry into bit 0 (add mode only).
REQ-011 Port sub, input, 1 bit: 0 selects A+B+carry_in; 1 selects A-B.
REQ-012 Port out_valid, output, 1 bit: the result beat is valid.
REQ-013 Port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-014 Port sum, output, WIDTH bits: result.
REQ-015 Port carry_out, output, 1 bit: carry out of the MSB; in sub mode, 1 means no borrow.
REQ-016 Port overflow, output, 1 bit: two's-complement signed overflow.
REQ-017 Port zero, output, 1 bit: 1 when sum equals 0.

Function
REQ-018 The block SHALL compute sum = A + B' + c0, where B' = B and c0 = carry_in when sub=0, and B' = ~B and c0 = 1 when sub=1 (carry_in is ignored in sub mode).
REQ-019 Carries SHALL be formed as per-bit P=A^B', G=A&B', then group propagate/generate of GROUP bits, then ripple-lookahead across groups: c[g+1] = G_g | (P_g & c[g]).
REQ-020 The group carry chain SHALL be split across STAGES register boundaries, with no combinational path from a/b to sum, carry_out, overflow or zero.
REQ-021 Latency SHALL be exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid with no stall; throughput SHALL be one beat per cycle.
REQ-022 overflow SHALL equal the carry into the MSB XOR carry_out; zero SHALL be registered alongside sum.
REQ-023 Each stage SHALL hold a valid bit; a beat advances only when the stage ahead is empty or is advancing itself in the same cycle.
REQ-024 in_ready SHALL be 1 when stage 1 is empty or stage 1 advances in the current cycle (bubble-collapsing backpressure).
REQ-025 While out_valid=1 and out_ready=0, sum, carry_out, overflow and zero SHALL hold stable and out_valid SHALL stay 1.
REQ-026 Simultaneous accept at the input and drain at the output in one cycle SHALL lose and duplicate no beat.
REQ-027 The pipeline SHALL hold at most STAGES beats; with all stages full and out_ready=0, in_ready SHALL be 0.
REQ-028 Beats SHALL emerge in acceptance order, each paired with its own sub and carry_in.
REQ-029 in_valid=0 cycles SHALL insert bubbles, and payload registers of empty stages are don't-care.

Reset
REQ-030 While rst_n=0, all stage valid bits, out_valid, sum, carry_out, overflow and zero SHALL be 0, and in_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats immediately, asynchronously to clk.
REQ-032 The first beat SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (WIDTH=32, GROUP=4, STAGES=2, out_ready=1 unless stated)
REQ-033 Add wrap: a=FFFFFFFF, b=00000001, carry_in=0, sub=0 -> 2 cycles later sum=00000000, carry_out=1, zero=1, overflow=0.
REQ-034 Subtract: a=00000005, b=00000007, sub=1, carry_in=1 (ignored) -> sum=FFFFFFFE, carry_out=0, overflow=0, zero=0.
REQ-035 Signed overflow: a=7FFFFFFF, b=00000001, sub=0 -> sum=80000000, overflow=1, carry_out=0; also a=80000000, b=00000001, sub=1 -> sum=7FFFFFFF, overflow=1.
REQ-036 Backpressure: stream 10 beats with out_ready held 0 for cycles 3-5 -> in_ready=0 once both stages are full, outputs stay stable, and all 10 results arrive in order.
REQ-037 Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately; after release, a fresh beat returns its result with latency 2.
REQ-038 Random sweep over STAGES 1..4 and GROUP 2/4/8: results SHALL match a behavioural reference model bit-exact, at a sustained rate of 1 beat per cycle.
